// File: rtl/delay_sched.sv
// delay_sched: shared-delay scheduler. A single CBITS-bit down-counter is time-shared among
// NREQ requesters. A rotating-priority arbiter grants one requester at a time. The scheduler
// counts that requester's delay, then pulses done back to it.
//
// Ports:
//   clk        in   clock, all state updates on posedge
//   rst        in   synchronous active-high reset
//   req        in   [NREQ]        per-requester level request, held until done/abort
//   dly        in   [NREQ*CBITS]  per-requester delay, slice i = dly[i*CBITS +: CBITS]
//   gnt        out  [NREQ]        one-hot owner of the counter
//   done       out  [NREQ]        one-hot one-cycle pulse when the owner's delay expires
//   abort      out  one-cycle pulse when the owner dropped req before done
//   busy       out  high while counting or signalling done
//   clamp_err  out  sticky flag: a granted delay exceeded MAXDLY (cleared by rst only)
//
// MAXDLY must be representable in CBITS bits.
module delay_sched #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned CBITS  = 17,
  parameter int unsigned MAXDLY = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*CBITS-1:0] dly,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  abort,
  output logic                  busy,
  output logic                  clamp_err
);

  localparam int unsigned PBITS = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [CBITS-1:0] MaxDly = CBITS'(MAXDLY);

  typedef enum logic [1:0] {StIdle, StCount, StDone} state_e;

  state_e             r_state, w_state_d;
  logic [CBITS-1:0]   r_cnt, w_cnt_d;
  logic [PBITS-1:0]   r_ptr, w_ptr_d;
  logic [PBITS-1:0]   r_win, w_win_d;
  logic [NREQ-1:0]    r_gnt, w_gnt_d;
  logic               r_abort, w_abort_d;
  logic               r_clamp_err, w_clamp_err_d;

  logic               w_found;
  logic [PBITS-1:0]   w_win_idx;
  int unsigned        w_idx;
  logic [CBITS-1:0]   w_sel_dly;
  logic [PBITS-1:0]   w_ptr_inc;

  // Rotating-priority search: first set req bit starting at r_ptr and wrapping.
  always_comb begin
    w_found   = 1'b0;
    w_win_idx = '0;
    w_idx     = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_idx = 32'(r_ptr) + k;
      if (w_idx >= NREQ) begin
        w_idx = w_idx - NREQ;
      end
      if (!w_found && req[w_idx[PBITS-1:0]]) begin
        w_found   = 1'b1;
        w_win_idx = w_idx[PBITS-1:0];
      end
    end
  end

  assign w_sel_dly = dly[32'(w_win_idx) * CBITS +: CBITS];

  // Next pointer starts the scan just after the requester that was served.
  assign w_ptr_inc = (32'(r_win) == NREQ - 1) ? '0 : r_win + PBITS'(1);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_ptr       <= '0;
      r_win       <= '0;
      r_gnt       <= '0;
      r_abort     <= 1'b0;
      r_clamp_err <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_ptr       <= w_ptr_d;
      r_win       <= w_win_d;
      r_gnt       <= w_gnt_d;
      r_abort     <= w_abort_d;
      r_clamp_err <= w_clamp_err_d;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_d     = r_state;
    w_cnt_d       = r_cnt;
    w_ptr_d       = r_ptr;
    w_win_d       = r_win;
    w_gnt_d       = r_gnt;
    w_abort_d     = 1'b0;
    w_clamp_err_d = r_clamp_err;
    case (r_state)
      StIdle: begin
        if (w_found) begin
          w_win_d = w_win_idx;
          w_gnt_d = NREQ'(1) << w_win_idx;
          if (w_sel_dly > MaxDly) begin
            w_cnt_d       = MaxDly;
            w_clamp_err_d = 1'b1;
          end else begin
            w_cnt_d = w_sel_dly;
          end
          w_state_d = StCount;
        end
      end
      StCount: begin
        // A dropped request wins over an expiring count in the same cycle.
        if (!req[r_win]) begin
          w_abort_d = 1'b1;
          w_gnt_d   = '0;
          w_ptr_d   = w_ptr_inc;
          w_state_d = StIdle;
        end else if (r_cnt == '0) begin
          w_state_d = StDone;
        end else begin
          w_cnt_d = r_cnt - CBITS'(1);
        end
      end
      StDone: begin
        w_gnt_d   = '0;
        w_ptr_d   = w_ptr_inc;
        w_state_d = StIdle;
      end
      default: begin
        w_gnt_d   = '0;
        w_state_d = StIdle;
      end
    endcase
  end

  // Outputs: all derived directly from registers.
  always_comb begin
    gnt       = r_gnt;
    done      = (r_state == StDone) ? r_gnt : '0;
    abort     = r_abort;
    busy      = (r_state != StIdle);
    clamp_err = r_clamp_err;
  end

endmodule

// File: doc/delay_sched.md
Name: delay_sched

Overview:
- Shared-delay scheduler: one CBITS-bit down-counter serves NREQ requesters, each asking for its own programmable wait.
- Round-robin arbitration picks one requester at a time. The scheduler counts that requester's delay, then returns a one-cycle done pulse to it.
- Sits in front of the periodic-delay datapath so several consumers can share a single timer instead of each instantiating its own.
- Liveness guarantee: every held request is eventually served.

Parameters:
- NREQ, 4, number of requesters (≥2)
- CBITS, 17, counter/delay width
- MAXDLY, 100000, largest accepted delay; larger requests are clamped

Ports:
- clk  in  1  clock, all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- req  in  NREQ  per-requester level request; held until that requester's done or abort
- dly  in  NREQ*CBITS  per-requester delay, slice i = dly[i*CBITS +: CBITS]; must be stable while req[i] is high
- gnt  out  NREQ  one-hot, registered; marks the requester currently owning the counter
- done  out  NREQ  one-hot one-cycle pulse, registered; delay for the granted requester has expired
- abort  out  1  one-cycle pulse; granted requester dropped req before done
- busy  out  1  high in COUNT or DONE
- clamp_err  out  1  sticky; set when a granted dly exceeded MAXDLY; cleared only by rst

Behaviour:
- Reset values:
  - State IDLE, cnt=0, ptr=0.
  - gnt=0, done=0, abort=0, busy=0, clamp_err=0.
  - Reset asserted mid-operation aborts the transfer silently: no done, no abort pulse.
- States: IDLE, COUNT, DONE.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise pick the winner w = first set bit of req scanning ptr, ptr+1, …, NREQ-1, 0, …, ptr-1.
  - Load cnt = min(dly[w], MAXDLY); set clamp_err if dly[w] > MAXDLY.
  - gnt <= onehot(w); go to COUNT.
- COUNT:
  - If req[w]==0: abort <= 1 for one cycle, gnt <= 0, ptr <= w+1 mod NREQ, go to IDLE.
  - Else if cnt==0: done <= onehot(w), go to DONE.
  - Else cnt <= cnt-1.
  - Abort check has priority over the cnt==0 check in the same cycle.
- DONE:
  - done is high for exactly this one cycle.
  - gnt <= 0, ptr <= w+1 mod NREQ, go to IDLE.
- Latency: with effective delay d latched at the grant edge:
  - COUNT lasts d+1 cycles; done is high in the cycle d+1 after the first COUNT cycle.
  - d=0 gives done in the second cycle after the grant edge.
- Requester protocol: drop req on the edge after seeing done. The scheduler always spends at least one IDLE cycle between grants, so a dropped req is never re-granted.
- Arbitration only in IDLE; requests arriving during COUNT/DONE wait. Rotating ptr bounds each requester's wait to NREQ-1 other services.
- Only one of done, abort per grant; both are never high in the same cycle; done is never high while gnt==0 except in DONE.
- Arithmetic: cnt is CBITS wide and never underflows (decrement only when cnt>0). MAXDLY must fit in CBITS.
- Properties to prove: gnt onehot0; done onehot0; for each i, !rst and req[i] held implies s_eventually done[i].

Test Plan:
- Single requester: req=0001, dly0=3 -> gnt=0001 next cycle; done=0001 exactly 5 cycles after grant edge; back to IDLE; busy low 1 cycle after done.
- Contention: req=1111 with all dly=1, each dropping req after its done -> done order 0,1,2,3, each done 3 cycles after its grant, one IDLE cycle between grants.
- Fairness: req0 re-asserts immediately after every done, req2 held constantly -> req2 granted no later than the second grant after reset.
- Clamp: dly1=120000 -> clamp_err=1 at grant; done after 100001 COUNT cycles; clamp_err stays 1 until rst.
- Abort: grant req3 with dly=10, drop req3 after 4 COUNT cycles -> abort pulse 1 cycle, no done, ptr=0, next grant goes to a pending req0.
- Reset mid-COUNT: rst at cnt=5 -> next cycle gnt=0, done=0, busy=0, ptr=0; held requests re-arbitrated from requester 0 after rst deasserts.
